// File: rtl/dvp_pattern_tx_if.sv
// dvp_pattern_tx_if: DVP sensor bus (cmos_pclk, cmos_href, cmos_vsync, cmos_db[7:0]); master drives it, slave captures it
interface dvp_pattern_tx_if;
  logic       cmos_pclk;
  logic       cmos_href;
  logic       cmos_vsync;
  logic [7:0] cmos_db;
  modport master(output cmos_pclk, cmos_href, cmos_vsync, cmos_db);
  modport slave(input cmos_pclk, cmos_href, cmos_vsync, cmos_db);
endinterface

// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: synthetic RGB565 DVP sensor (clk, rst_n, en, pattern in; dvp bus, frame_cnt, frame_done, busy out)
module dvp_pattern_tx #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned PCLK_HALF   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            pattern,
  dvp_pattern_tx_if.master      dvp,
  output logic [15:0]           frame_cnt,
  output logic                  frame_done,
  output logic                  busy
);
  localparam int unsigned L  = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned BW = $clog2(L);
  localparam int unsigned DW = PCLK_HALF > 1 ? $clog2(PCLK_HALF) : 1;
  localparam logic [7:0][15:0] BARS = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                       16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};
  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
  state_t          state_q, state_d;
  logic [DW-1:0]   div_q;
  logic            pclk_q, href_q, vsync_q, done_q;
  logic [7:0]      db_q;
  logic [BW-1:0]   b_q, b_d;
  logic [15:0]     ln_q, ln_d, cnt_q, n_lines, x, bar, pix;
  logic [1:0]      pat_q, pat_d;
  logic            term, tick, eol, last_line, eof, href_d;
  assign term      = div_q == DW'(PCLK_HALF - 1);
  assign tick      = term & pclk_q;
  assign eol       = b_q == BW'(L - 1);
  assign n_lines   = state_q == VSYNC ? 16'(VSYNC_LINES) :
                     state_q == VBACK ? 16'(V_BACK) :
                     state_q == ACTIVE ? 16'(V_ACTIVE) : 16'(V_FRONT);
  assign last_line = ln_q == n_lines - 16'd1;
  assign eof       = tick && state_q == VFRONT && eol && last_line;
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    ln_d    = ln_q;
    pat_d   = pat_q;
    if (tick && state_q == IDLE) begin
      if (en) begin
        state_d = VSYNC;
        pat_d   = pattern;
      end
    end else if (tick) begin
      b_d = eol ? '0 : b_q + 1'b1;
      if (eol) begin
        ln_d = last_line ? 16'd0 : ln_q + 16'd1;
        if (last_line)
          state_d = state_q == VSYNC ? VBACK :
                    state_q == VBACK ? ACTIVE :
                    state_q == ACTIVE ? VFRONT : (en ? VSYNC : IDLE);
        if (eof && en) pat_d = pattern;
      end
    end
  end
  // Outputs are computed from the next position so they change together with it on the tick.
  assign x      = 16'(b_d >> 1);
  assign bar    = x / 16'(H_ACTIVE / 8);
  assign pix    = pat_d == 2'd0 ? BARS[bar > 16'd7 ? 3'd7 : bar[2:0]] :
                  pat_d == 2'd1 ? {x[5:1], x[5:0], x[5:1]} :
                  pat_d == 2'd2 ? {16{x[5] ^ ln_d[5]}} : {cnt_q[7:0], x[7:0]};
  assign href_d = state_d == ACTIVE && b_d < BW'(2 * H_ACTIVE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      pclk_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
      b_q     <= '0;
      ln_q    <= '0;
      pat_q   <= '0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      db_q    <= '0;
    end else begin
      div_q  <= term ? '0 : div_q + 1'b1;
      pclk_q <= pclk_q ^ term;
      done_q <= eof;
      if (eof) cnt_q <= cnt_q + 16'd1;
      if (tick) begin
        state_q <= state_d;
        b_q     <= b_d;
        ln_q    <= ln_d;
        pat_q   <= pat_d;
        href_q  <= href_d;
        vsync_q <= state_d == VSYNC;
        db_q    <= href_d ? (b_d[0] ? pix[7:0] : pix[15:8]) : 8'd0;
      end
    end
  end
  assign dvp.cmos_pclk  = pclk_q;
  assign dvp.cmos_href  = href_q;
  assign dvp.cmos_vsync = vsync_q;
  assign dvp.cmos_db    = db_q;
  assign frame_cnt      = cnt_q;
  assign frame_done     = done_q;
  assign busy           = state_q != IDLE;
endmodule
